// File: rtl/alu_pkg.sv
// Shared types for the ALU/shifter pipeline: data-processing opcodes,
// shifter operand encodings and the bit positions inside the flag register.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IMM_SHIFT = 3'b000,
        ST_ROT_IMM   = 3'b001,
        ST_LS_IMM    = 3'b010,
        ST_LS_REG    = 3'b011
    } shift_type_e;

    typedef enum logic [1:0] {
        SK_LSL = 2'b00,
        SK_LSR = 2'b01,
        SK_ASR = 2'b10,
        SK_ROR = 2'b11
    } shift_kind_e;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // TST/TEQ/CMP/CMN: no register write, flags always updated.
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational shifter operand generator. Anything that depends on the
// carry flag is reported (needs_c_o / c_to_msb_o) rather than computed here.
module barrel_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rm_i,
    input  logic [11:0]      shift_ctl_i,
    input  logic [2:0]       shift_type_i,
    output logic [WIDTH-1:0] value_o,
    output logic             carry_o,
    output logic             needs_c_o,
    output logic             c_to_msb_o
);

    localparam int IW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] v, input logic [4:0] n);
        if (n == 5'd0) return v;
        return (v >> n) | (v << (WIDTH - int'(n)));
    endfunction

    logic [4:0]       amt;
    logic [4:0]       rot;
    shift_kind_e      kind;
    logic [IW-1:0]    lsl_idx;
    logic [IW-1:0]    lsr_idx;
    logic [WIDTH-1:0] rot_val;

    always_comb begin
        amt        = shift_ctl_i[11:7];
        kind       = shift_kind_e'(shift_ctl_i[6:5]);
        rot        = {shift_ctl_i[11:8], 1'b0};
        lsl_idx    = IW'(WIDTH - int'(amt));
        lsr_idx    = IW'(int'(amt) - 1);
        rot_val    = ror(WIDTH'(shift_ctl_i[7:0]), rot);
        value_o    = rm_i;
        carry_o    = 1'b0;
        needs_c_o  = 1'b0;
        c_to_msb_o = 1'b0;
        case (shift_type_i)
            ST_IMM_SHIFT: begin
                if (amt == 5'd0) begin
                    // Zero amount encodes LSR#32, ASR#32 and RRX.
                    case (kind)
                        SK_LSL: needs_c_o = 1'b1;
                        SK_LSR: begin
                            value_o = '0;
                            carry_o = rm_i[WIDTH-1];
                        end
                        SK_ASR: begin
                            value_o = {WIDTH{rm_i[WIDTH-1]}};
                            carry_o = rm_i[WIDTH-1];
                        end
                        SK_ROR: begin
                            value_o    = {1'b0, rm_i[WIDTH-1:1]};
                            carry_o    = rm_i[0];
                            c_to_msb_o = 1'b1;
                        end
                    endcase
                end else begin
                    case (kind)
                        SK_LSL: begin
                            value_o = rm_i << amt;
                            carry_o = rm_i[lsl_idx];
                        end
                        SK_LSR: begin
                            value_o = rm_i >> amt;
                            carry_o = rm_i[lsr_idx];
                        end
                        SK_ASR: begin
                            value_o = $unsigned($signed(rm_i) >>> amt);
                            carry_o = rm_i[lsr_idx];
                        end
                        SK_ROR: begin
                            value_o = ror(rm_i, amt);
                            carry_o = rm_i[lsr_idx];
                        end
                    endcase
                end
            end
            ST_ROT_IMM: begin
                value_o   = rot_val;
                carry_o   = rot_val[WIDTH-1];
                needs_c_o = (rot == 5'd0);
            end
            ST_LS_IMM: begin
                value_o   = WIDTH'(shift_ctl_i);
                needs_c_o = 1'b1;
            end
            default: begin
                value_o   = rm_i;
                needs_c_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_shifter_pipe.sv
// Two-stage data-processing pipe: S1 holds the shifter output, S2 the ALU
// operands; result and flag update are evaluated from S2 and committed flags.
module alu_shifter_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] rm,
    input  logic [11:0]      shift_ctl,
    input  logic [2:0]       shift_type,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       flags
);

    typedef struct packed {
        opcode_e          op;
        logic             set_flags;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             carry;
        logic             needs_c;
        logic             c_to_msb;
    } stage_t;

    stage_t s1_q, s1_d, s2_q;
    logic   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic   s1_adv, s2_adv;
    logic [3:0] flags_q, flags_d;
    logic   commit;

    logic [WIDTH-1:0] sh_val;
    logic             sh_carry, sh_needs_c, sh_c_to_msb;

    barrel_shifter #(.WIDTH(WIDTH)) u_shifter (
        .rm_i         (rm),
        .shift_ctl_i  (shift_ctl),
        .shift_type_i (shift_type),
        .value_o      (sh_val),
        .carry_o      (sh_carry),
        .needs_c_o    (sh_needs_c),
        .c_to_msb_o   (sh_c_to_msb)
    );

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign flags     = flags_q;

    always_comb begin
        s1_d           = '0;
        s1_d.op        = opcode_e'(opcode);
        s1_d.set_flags = set_flags;
        s1_d.a         = op_a;
        s1_d.b         = sh_val;
        s1_d.carry     = sh_carry;
        s1_d.needs_c   = sh_needs_c;
        s1_d.c_to_msb  = sh_c_to_msb;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) s2_valid_d = s1_valid_q;
            if (s1_adv) s1_valid_d = in_valid;
        end
    end

    // S2 evaluation: carry-dependent operand bits are resolved here against
    // the committed flags, so a back-to-back successor sees fresh C.
    logic             c_in, sh_c, arith, alu_cin, ovf;
    logic [WIDTH-1:0] op_b, alu_x, alu_y, logic_res, res;
    logic [WIDTH:0]   sum;

    always_comb begin
        c_in = flags_q[FLAG_C];
        op_b = s2_q.b;
        if (s2_q.c_to_msb) op_b[WIDTH-1] = c_in;
        sh_c      = s2_q.needs_c ? c_in : s2_q.carry;
        alu_x     = s2_q.a;
        alu_y     = op_b;
        alu_cin   = 1'b0;
        arith     = 1'b0;
        logic_res = '0;
        case (s2_q.op)
            OP_AND, OP_TST: logic_res = s2_q.a & op_b;
            OP_EOR, OP_TEQ: logic_res = s2_q.a ^ op_b;
            OP_SUB, OP_CMP: begin arith = 1'b1; alu_y = ~op_b; alu_cin = 1'b1; end
            OP_RSB:         begin arith = 1'b1; alu_x = op_b; alu_y = ~s2_q.a; alu_cin = 1'b1; end
            OP_ADD, OP_CMN: arith = 1'b1;
            OP_ADC:         begin arith = 1'b1; alu_cin = c_in; end
            OP_SBC:         begin arith = 1'b1; alu_y = ~op_b; alu_cin = c_in; end
            OP_RSC:         begin arith = 1'b1; alu_x = op_b; alu_y = ~s2_q.a; alu_cin = c_in; end
            OP_ORR:         logic_res = s2_q.a | op_b;
            OP_MOV:         logic_res = op_b;
            OP_BIC:         logic_res = s2_q.a & ~op_b;
            OP_MVN:         logic_res = ~op_b;
        endcase
        sum = {1'b0, alu_x} + {1'b0, alu_y} + {{WIDTH{1'b0}}, alu_cin};
        res = arith ? sum[WIDTH-1:0] : logic_res;
        ovf = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (sum[WIDTH-1] != alu_x[WIDTH-1]);

        flags_d         = flags_q;
        flags_d[FLAG_N] = res[WIDTH-1];
        flags_d[FLAG_Z] = (res == '0);
        flags_d[FLAG_C] = arith ? sum[WIDTH] : sh_c;
        if (arith) flags_d[FLAG_V] = ovf;
    end

    assign result = res;
    assign wr_en  = !is_compare(s2_q.op);
    assign commit = s2_valid_q && out_ready && !flush &&
                    (s2_q.set_flags || is_compare(s2_q.op));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            flags_q    <= 4'b0000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_adv && in_valid)     s1_q    <= s1_d;
            if (s2_adv && s1_valid_q)   s2_q    <= s1_q;
            if (commit)                 flags_q <= flags_d;
        end
    end

endmodule
